// File: rtl/cu_sequencer.sv
// cu_sequencer: microstep counter, one-hot CPU_state, stall and halt/resume control.
// Optional single-step debug port (step_mode/step_go) enabled by CU_SINGLE_STEP_EN.
module cu_sequencer #(
  parameter int STATES = 40,
  parameter int OPW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              COUNTER_LD,
  input  logic              COUNTER_INC,
  input  logic              COUNTER_CLR,
  input  logic              stall,
  input  logic              halt_req,
`ifdef CU_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step_go,
`endif
  output logic [STATES-1:0] CPU_state,
  output logic [5:0]        step_idx,
  output logic              instr_done,
  output logic              halted,
  output logic              illegal_op
);

  localparam logic [5:0]        NOP1 = 6'd3;
  localparam logic [5:0]        LAST = 6'(STATES - 1);
  localparam logic [STATES-1:0] ONE  = {{(STATES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN,
    HALT_PEND,
    HALTED
  } fsm_t;

  fsm_t       fsm;
  logic [5:0] start;
  logic       op_ok;
  logic [5:0] nxt;
  logic       retire;
  logic       bad_op;
  logic       at0;
  logic       proceed;
  logic       park;
  logic       resume;
  logic       smode;
  logic       go_rise;

`ifdef CU_SINGLE_STEP_EN
  logic go_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) go_q <= 1'b0;
    else     go_q <= step_go;
  end

  assign smode   = step_mode;
  assign go_rise = step_go & ~go_q;
`else
  assign smode   = 1'b0;
  assign go_rise = 1'b0;
`endif

  always_comb begin
    start = NOP1;
    op_ok = 1'b1;
    case (opcode)
      OPW'(0):  start = 6'd3;
      OPW'(1):  start = 6'd4;
      OPW'(2):  start = 6'd5;
      OPW'(3):  start = 6'd7;
      OPW'(4):  start = 6'd9;
      OPW'(5):  start = 6'd13;
      OPW'(6):  start = 6'd17;
      OPW'(7):  start = 6'd21;
      OPW'(8):  start = 6'd22;
      OPW'(9):  start = 6'd23;
      OPW'(10): start = 6'd24;
      OPW'(11): start = 6'd25;
      OPW'(12): start = 6'd26;
      OPW'(13): start = 6'd28;
      OPW'(14): start = 6'd30;
      OPW'(15): start = 6'd32;
      OPW'(16): start = 6'd34;
      OPW'(17): start = 6'd36;
      OPW'(18): start = 6'd38;
      default:  op_ok = 1'b0;
    endcase
  end

  // nop1 has no strobes of its own, so step 3 returns to fetch1 unaided
  always_comb begin
    nxt    = step_idx;
    retire = 1'b0;
    bad_op = 1'b0;
    if (COUNTER_CLR || step_idx == NOP1) begin
      nxt    = 6'd0;
      retire = 1'b1;
    end else if (COUNTER_LD) begin
      nxt    = start;
      bad_op = ~op_ok;
    end else if (COUNTER_INC) begin
      nxt = (step_idx == LAST) ? 6'd0 : step_idx + 6'd1;
    end
  end

  assign at0     = (step_idx == 6'd0);
  assign proceed = (fsm == RUN && !(halt_req && at0)) ||
                   (fsm == HALT_PEND);
  assign park    = retire && (halt_req || smode);
  assign resume  = smode ? (go_rise & ~halt_req) : ~halt_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= RUN;
      step_idx   <= 6'd0;
      CPU_state  <= ONE;
      instr_done <= 1'b0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else if (stall) begin
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      instr_done <= proceed & retire;
      illegal_op <= proceed & bad_op;
      if (proceed) begin
        step_idx  <= nxt;
        CPU_state <= ONE << nxt;
      end
      unique case (fsm)
        RUN: begin
          if (halt_req && at0) begin
            fsm    <= HALTED;
            halted <= 1'b1;
          end else if (park) begin
            fsm    <= HALTED;
            halted <= 1'b1;
          end else if (halt_req) begin
            fsm <= HALT_PEND;
          end
        end
        HALT_PEND: begin
          if (park) begin
            fsm    <= HALTED;
            halted <= 1'b1;
          end else if (!halt_req) begin
            fsm <= RUN;
          end
        end
        HALTED: begin
          step_idx  <= 6'd0;
          CPU_state <= ONE;
          if (resume) begin
            fsm    <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          fsm    <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: scoreboard bench for cu_sequencer.
// Build with +define+CU_SINGLE_STEP_EN to cover the single-step port.
module tb_cu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  opcode = '0;
  logic        ld = 1'b0;
  logic        inc = 1'b0;
  logic        clr = 1'b0;
  logic        stall = 1'b0;
  logic        hreq = 1'b0;
  logic        step_mode = 1'b0;
  logic        step_go = 1'b0;
  logic [39:0] cpu_state;
  logic [5:0]  step_idx;
  logic        instr_done;
  logic        halted;
  logic        illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   st;
    logic done;
    logic ill;
    logic hlt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cu_sequencer #(.STATES(40), .OPW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .COUNTER_LD (ld),
    .COUNTER_INC(inc),
    .COUNTER_CLR(clr),
    .stall      (stall),
    .halt_req   (hreq),
`ifdef CU_SINGLE_STEP_EN
    .step_mode  (step_mode),
    .step_go    (step_go),
`endif
    .CPU_state  (cpu_state),
    .step_idx   (step_idx),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic l, input logic i,
                     input logic [4:0] op, input logic st,
                     input logic h, input int es, input logic ed,
                     input logic ei, input logic eh);
    exp_t e;
    logic [39:0] one;
    clr    = c;
    ld     = l;
    inc    = i;
    opcode = op;
    stall  = st;
    hreq   = h;
    sb.push_back('{es, ed, ei, eh});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    one = 40'h1;
    chk("step", 64'(step_idx), 64'(e.st));
    chk("cpu_state", 64'(cpu_state), 64'(one << e.st));
    chk("done", 64'(instr_done), 64'(e.done));
    chk("illegal", 64'(illegal_op), 64'(e.ill));
    chk("halted", 64'(halted), 64'(e.hlt));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_step", 64'(step_idx), 64'd0);
    chk("rst_state", 64'(cpu_state), 64'h1);
    chk("rst_done", 64'(instr_done), 64'd0);
    chk("rst_halt", 64'(halted), 64'd0);
    chk("rst_ill", 64'(illegal_op), 64'd0);
    rst = 1'b0;

    // fetch, load ldr, reach ldr2, then async reset
    cyc(0,1'b0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd3,0,0, 7,0,0,0);
    cyc(0,0,1,5'd0,0,0, 8,0,0,0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_state", 64'(cpu_state), 64'h1);
    chk("mid_rst_step", 64'(step_idx), 64'd0);
    chk("mid_rst_done", 64'(instr_done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // add routine
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd12,0,0, 26,0,0,0);
    cyc(0,0,1,5'd0,0,0, 27,0,0,0);
    cyc(1,0,0,5'd0,0,0, 0,1,0,0);
    cyc(0,0,0,5'd0,0,0, 0,0,0,0);

    // unmapped opcode -> nop1 -> auto return
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd25,0,0, 3,0,1,0);
    cyc(0,0,0,5'd0,0,0, 0,1,0,0);
    cyc(0,0,0,5'd0,0,0, 0,0,0,0);

    // legal nop
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd0,0,0, 3,0,0,0);
    cyc(0,0,0,5'd0,0,0, 0,1,0,0);

    // strobe priority and stall
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(1,1,1,5'd12,0,0, 0,1,0,0);
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    for (int k = 0; k < 3; k++)
      cyc(0,0,1,5'd0,1,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(1,0,0,5'd0,1,0, 2,0,0,0);
    cyc(1,0,0,5'd0,0,0, 0,1,0,0);

    // last step wraps without retire
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd18,0,0, 38,0,0,0);
    cyc(0,0,1,5'd0,0,0, 39,0,0,0);
    cyc(0,0,1,5'd0,0,0, 0,0,0,0);
    cyc(0,0,0,5'd0,0,0, 0,0,0,0);

    // halt requested inside mul
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd14,0,0, 30,0,0,0);
    cyc(0,0,1,5'd0,0,1, 31,0,0,0);
    cyc(1,0,0,5'd0,0,1, 0,1,0,1);
    cyc(0,0,1,5'd0,0,1, 0,0,0,1);
    cyc(0,0,1,5'd0,0,0, 0,0,0,0);
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);

    // halt at fetch1
    cyc(1,0,0,5'd0,0,0, 0,1,0,0);
    cyc(0,0,1,5'd0,0,1, 0,0,0,1);
    cyc(0,0,0,5'd0,0,0, 0,0,0,0);
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);

    // pending halt withdrawn
    cyc(0,0,1,5'd0,0,1, 2,0,0,0);
    cyc(0,1,0,5'd12,0,0, 26,0,0,0);
    cyc(1,0,0,5'd0,0,0, 0,1,0,0);
    cyc(0,0,0,5'd0,0,0, 0,0,0,0);

    // stalled illegal load is dropped
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd25,1,0, 2,0,0,0);
    cyc(0,1,0,5'd25,0,0, 3,0,1,0);
    cyc(0,0,0,5'd0,0,0, 0,1,0,0);

`ifdef CU_SINGLE_STEP_EN
    step_mode = 1'b1;
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd12,0,0, 26,0,0,0);
    cyc(1,0,0,5'd0,0,0, 0,1,0,1);
    cyc(0,0,1,5'd0,0,0, 0,0,0,1);
    step_go = 1'b1;
    cyc(0,0,0,5'd0,0,0, 0,0,0,0);
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
    cyc(0,0,1,5'd0,0,0, 2,0,0,0);
    cyc(0,1,0,5'd12,0,0, 26,0,0,0);
    cyc(1,0,0,5'd0,0,0, 0,1,0,1);
    cyc(0,0,1,5'd0,0,0, 0,0,0,1);
    step_mode = 1'b0;
    step_go   = 1'b0;
    cyc(0,0,0,5'd0,0,0, 0,0,0,0);
    cyc(0,0,1,5'd0,0,0, 1,0,0,0);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
